mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the native valid/ready memory bus.
- Master 0 is the picorv32 CPU. Master 1 is a second requester, e.g. DMA or a debug loader.
- The single slave port drives the existing address decoder (ROM/RAM/UART/LED).
- Round-robin by default. One transaction in flight. Grant is held until the slave returns ready.

Parameters:
- FIXED_PRIO, 0, 1 = master 0 always wins ties; 0 = round-robin.
- TIMEOUT_CYCLES, 256, slave-response cycle limit. Used only when ARB_TIMEOUT_EN is defined; must be ≥2.
- ERR_RDATA, 32'hDEADBEEF, read data returned on a timed-out transaction.

Ports:
- clk  in  1  single system clock; all state on posedge
- rstn  in  1  asynchronous active-low reset
- m0_valid / m1_valid  in  1  master request
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid while the matching ready is high
- s_valid  out  1  request to the slave decoder
- s_addr  out  32  muxed address
- s_wdata  out  32  muxed write data
- s_wstrb  out  4  muxed strobes
- s_ready  in  1  slave completion pulse (registered in the decoder)
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 00 = idle
- timeout_err  out  1  one-cycle pulse on timeout; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, grant=00, last_grant=1 (so m0 wins the first tie).
  - s_valid=0, m0_ready=m1_ready=0, timeout_err=0, timeout counter=0.
  - Outputs fall immediately, without waiting for a clock edge.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only m0_valid → OWN0. Only m1_valid → OWN1.
  - Both valid, FIXED_PRIO=1 → OWN0.
  - Both valid, FIXED_PRIO=0 → the master that is not last_grant.
  - No request → stay in IDLE.
- OWNx outputs:
  - grant is one-hot x.
  - s_valid = mx_valid (combinational from the state register).
  - s_addr/s_wdata/s_wstrb = master x fields. In IDLE they carry master 0 fields with s_valid=0.
- Completion (OWNx and s_ready=1, same cycle):
  - mx_ready=1 and mx_rdata=s_rdata, combinational pass-through.
  - Next state IDLE; last_grant<=x.
  - The non-granted master sees ready=0 and rdata=0.
- Latency: request in IDLE at cycle N → s_valid at N+1 → earliest mx_ready at N+2 (decoder adds one cycle).
  - One IDLE bubble between back-to-back transactions, so the master can drop valid.
- Protocol violation (mx_valid falls while OWNx, no s_ready):
  - → IDLE next cycle; s_valid follows mx_valid low at once.
  - last_grant is not updated.
- s_ready while IDLE (stray pulse): ignored; no master ready.
- Both masters hold valid continuously with FIXED_PRIO=0: grants strictly alternate 0,1,0,1.
- A starved master never waits more than one transaction of the other.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to OWNx and increments each OWNx cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES-1 and s_ready is still low: mx_ready=1, mx_rdata=ERR_RDATA, timeout_err=1, all for one cycle.
  - In that same cycle s_valid is forced 0; then → IDLE and last_grant<=x.
  - If s_ready arrives on the terminal cycle, the normal completion wins and no error is flagged.
- Undefined: no counter logic; timeout_err tied 0; a hung slave holds the grant forever.

Decomposition:
- Package arb_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2;
  - default ERR_RDATA constant;
  - the round-robin pick function (inputs m0_valid, m1_valid, last_grant, fixed_prio).
- No sub-module: the FSM, output muxes and timeout counter stay in one module (~200 lines).

Test Plan:
- Reset release, m0 read addr 0x0000_0010, slave returns 0x1234_5678 → s_valid at N+1, m0_ready at N+2 with rdata=0x1234_5678, grant 01 then 00.
- m0 and m1 both request in the same cycle after reset, FIXED_PRIO=0 → m0 served first, then m1 after one IDLE bubble. Both held high for 6 transactions → grant order 0,1,0,1,0,1.
- Same as above with FIXED_PRIO=1, both held high → m0 served every transaction, m1 never granted.
- m1 write addr 0x1000_0004 wdata 0xCAFEF00D wstrb 4'b0011 while m0 idle → s_addr/s_wdata/s_wstrb equal m1 values during OWN1; m0_ready stays 0.
- rstn pulsed low mid-OWN1 → s_valid and grant drop immediately. After release both requesting → m0 granted first.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, s_ready held 0 on an m0 read → m0_ready and timeout_err pulse on the 8th OWN0 cycle with rdata=0xDEADBEEF, then IDLE. Without the macro, m0_ready never asserts.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, constants and pick function for mem_bus_arbiter
//
// Contents:
//   ST_IDLE/ST_OWN0/ST_OWN1  state encodings
//   arb_state_t              FSM state enum built on those encodings
//   ERR_RDATA_DEFAULT        read data returned on a timed-out transaction
//   rr_pick()                IDLE arbitration decision
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN0 = ST_OWN0,
    OWN1 = ST_OWN1
  } arb_state_t;

  // last_grant: 0 = master 0 was served last, 1 = master 1 was served last.
  // On a tie the master that was not served last wins, unless fixed_prio
  // forces master 0.
  function automatic arb_state_t rr_pick(
    input logic m0_valid,
    input logic m1_valid,
    input logic last_grant,
    input logic fixed_prio
  );
    arb_state_t pick;
    pick = IDLE;
    if (m0_valid && m1_valid) begin
      if (fixed_prio || last_grant) pick = OWN0;
      else                          pick = OWN1;
    end else if (m0_valid) begin
      pick = OWN0;
    end else if (m1_valid) begin
      pick = OWN1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master to one-slave valid/ready memory bus arbiter
//
// One transaction in flight; the grant is held until the slave returns ready.
// Round-robin by default, fixed priority to master 0 when FIXED_PRIO=1.
// Optional slave-response timeout is built when ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   m0_* / m1_*                   master requests (valid, addr, wdata, wstrb)
//                                 and responses (ready pulse, rdata)
//   s_valid/s_addr/s_wdata/s_wstrb request muxed to the slave decoder
//   s_ready/s_rdata               slave completion pulse and read data
//   grant                         one-hot current owner, 00 = idle
//   timeout_err                   one-cycle timeout pulse (0 without ARB_TIMEOUT_EN)
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int          FIXED_PRIO     = 0,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       own_valid;
  logic       done;
  logic       tmo_hit;
  logic [31:0] resp_rdata;

  // Request valid of whichever master currently owns the bus.
  always_comb begin
    own_valid = 1'b0;
    case (state)
      OWN0:    own_valid = m0_valid;
      OWN1:    own_valid = m1_valid;
      default: own_valid = 1'b0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counter is zero in IDLE, so every OWNx entry starts from zero; it counts
  // owned cycles that pass without a slave response.
  assign tmo_hit = (state != IDLE) && own_valid && !s_ready && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if ((state == IDLE) || s_ready || tmo_hit || !own_valid) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    done           = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = rr_pick(m0_valid, m1_valid, last_grant, FIXED_PRIO != 0);
      end
      OWN0, OWN1: begin
        if (s_ready || tmo_hit) begin
          done           = 1'b1;
          state_nxt      = IDLE;
          last_grant_nxt = (state == OWN1);
        end else if (!own_valid) begin
          // Master withdrew its request: release without crediting it.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant       = {state == OWN1, state == OWN0};
  assign s_valid     = own_valid && !tmo_hit;
  assign s_addr      = (state == OWN1) ? m1_addr  : m0_addr;
  assign s_wdata     = (state == OWN1) ? m1_wdata : m0_wdata;
  assign s_wstrb     = (state == OWN1) ? m1_wstrb : m0_wstrb;
  assign timeout_err = tmo_hit;

  // A timeout is only possible when s_ready is low, so the error word never
  // masks a real slave response.
  assign resp_rdata = tmo_hit ? ERR_RDATA : s_rdata;

  assign m0_ready = done && (state == OWN0);
  assign m1_ready = done && (state == OWN1);
  assign m0_rdata = m0_ready ? resp_rdata : 32'd0;
  assign m1_rdata = m1_ready ? resp_rdata : 32'd0;

endmodule
